nios_pio_in: RTL

NIOS_PIO_IN -- requirements
Module: nios_pio_in

---
 rtl/nios_pio_in_if.sv | 33 +++
 rtl/nios_pio_in.sv | 128 ++++++++++++
 2 files changed

// File: rtl/nios_pio_in_if.sv
// Avalon-MM slave bus for the nios_pio_in input port block.
// Zero-wait-state slave: a read is accepted on any clock edge where chipselect & ~read_n
// holds and readdata is valid the following cycle; a write is accepted on any edge where
// chipselect & ~write_n holds. There is no waitrequest, so every strobe completes at once.
interface nios_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/nios_pio_in.sv
// Avalon-MM parallel input port: synchronized pins, edge capture with masked level irq.
// Define NIOS_PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter after the synchronizer.
module nios_pio_in #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  nios_pio_in_if.slave     bus,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic             wr_en;
  logic             rd_en;
  logic             unused_writedata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;

  // Upper writedata bits are ignored when WIDTH < 32.
  assign unused_writedata = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] f_q;

  // f only follows s2 after s2 has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == f_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          f_q[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign f = f_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign f = s2;
`endif

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = f & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~f & prev;
    end else begin : g_any
      assign edge_det = f ^ prev;
    end
  endgenerate

  assign ec_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // A fresh edge outranks a same-cycle write-1-to-clear on that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      prev        <= f;
      edgecapture <= (edgecapture & ~ec_clr) | edge_det;
      if (wr_en && bus.address == 2'd2) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = 32'(f);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  // Sampled from pre-edge register values, so a simultaneous write is not visible yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edgecapture & irqmask);

endmodule
